// File: rtl/key_schedule_gen_pkg.sv
// -----------------------------------------------------------------------------
// key_schedule_gen_pkg
// Shared definitions for the DES key schedule generator:
//   - width constants (KEY_W, SUBKEY_W, HALF_W, CD_W, NUM_ROUNDS)
//   - FSM state type
//   - PC-1 (56 entries) and PC-2 (48 entries) tables, in standard DES 1-based
//     bit numbering, where DES bit 1 is the MSB of the vector
//   - 16-entry left-rotation schedule
//   - helpers for PC-1 and for the 28-bit circular rotation
// -----------------------------------------------------------------------------
package key_schedule_gen_pkg;

    localparam int KEY_W      = 64;
    localparam int SUBKEY_W   = 48;
    localparam int HALF_W     = 28;
    localparam int CD_W       = 2 * HALF_W;
    localparam int NUM_ROUNDS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } ks_state_t;

    // Entry j holds the DES key bit number that becomes C||D bit j+1.
    localparam int PC1_TABLE [CD_W] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Entry j holds the C||D bit number that becomes subkey bit j+1.
    localparam int PC2_TABLE [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Left rotation per round; the sum over all rounds is 28, so C and D
    // return to their PC-1 values after round 16.
    localparam logic [1:0] SHIFT_TABLE [NUM_ROUNDS] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // DES bit n of the key lives at key[KEY_W-n]; C||D bit n at cd[CD_W-n].
    function automatic logic [CD_W-1:0] pc1_permute(input logic [KEY_W-1:0] key);
        logic [CD_W-1:0] cd;
        cd = '0;
        for (int j = 0; j < CD_W; j++) begin
            cd[6'(CD_W - 1 - j)] = key[6'(KEY_W - PC1_TABLE[j])];
        end
        return cd;
    endfunction

    // DES "left shift" moves bit 1 (the MSB here) around to the LSB end.
    function automatic logic [HALF_W-1:0] rotl_half(input logic [HALF_W-1:0] v,
                                                    input logic [1:0]        amount);
        logic [HALF_W-1:0] r;
        if (amount == 2'd2) begin
            r = {v[HALF_W-3:0], v[HALF_W-1:HALF_W-2]};
        end else begin
            r = {v[HALF_W-2:0], v[HALF_W-1]};
        end
        return r;
    endfunction

endpackage

// File: rtl/key_schedule_gen_pc2_permutation.sv
// -----------------------------------------------------------------------------
// pc2_permutation
// Purely combinational DES Permuted Choice 2.
// Ports:
//   cd_in      [55:0]  rotated C||D, C in bits 55:28 (DES bit 1 = bit 55)
//   subkey_out [47:0]  round subkey (DES subkey bit 1 = bit 47)
// -----------------------------------------------------------------------------
module pc2_permutation
    import key_schedule_gen_pkg::*;
(
    input  logic [CD_W-1:0]     cd_in,
    output logic [SUBKEY_W-1:0] subkey_out
);

    // PC-2 drops C||D bits 9, 18, 22, 25, 35, 38, 43 and 54 by definition.
    logic dropped_bits_unused;
    assign dropped_bits_unused = ^{cd_in[47], cd_in[38], cd_in[34], cd_in[31],
                                   cd_in[21], cd_in[18], cd_in[13], cd_in[2]};

    always_comb begin
        subkey_out = '0;
        for (int j = 0; j < SUBKEY_W; j++) begin
            subkey_out[6'(SUBKEY_W - 1 - j)] = cd_in[6'(CD_W - PC2_TABLE[j])];
        end
    end

endmodule

// File: rtl/key_schedule_gen.sv
// -----------------------------------------------------------------------------
// key_schedule_gen
// Iterative DES key schedule: one round subkey per clock, 16 GEN cycles.
// Ports:
//   clk                    clock, rising edge
//   rst                    synchronous active-high reset
//   key_in        [63:0]   DES key, bit 63 = DES bit 1, parity bits ignored
//   key_valid              key_in presented for capture
//   decrypt                sampled with the key; 1 = present K16..K1
//   key_ready              a key can be accepted this cycle
//   subkey_0..subkey_15    [47:0] round subkeys, subkey_0 feeds round 1
//   subkeys_valid          all 16 subkeys are valid for the captured key
// -----------------------------------------------------------------------------
module key_schedule_gen
    import key_schedule_gen_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_W-1:0]    key_in,
    input  logic                key_valid,
    input  logic                decrypt,
    output logic                key_ready,
    output logic [SUBKEY_W-1:0] subkey_0,
    output logic [SUBKEY_W-1:0] subkey_1,
    output logic [SUBKEY_W-1:0] subkey_2,
    output logic [SUBKEY_W-1:0] subkey_3,
    output logic [SUBKEY_W-1:0] subkey_4,
    output logic [SUBKEY_W-1:0] subkey_5,
    output logic [SUBKEY_W-1:0] subkey_6,
    output logic [SUBKEY_W-1:0] subkey_7,
    output logic [SUBKEY_W-1:0] subkey_8,
    output logic [SUBKEY_W-1:0] subkey_9,
    output logic [SUBKEY_W-1:0] subkey_10,
    output logic [SUBKEY_W-1:0] subkey_11,
    output logic [SUBKEY_W-1:0] subkey_12,
    output logic [SUBKEY_W-1:0] subkey_13,
    output logic [SUBKEY_W-1:0] subkey_14,
    output logic [SUBKEY_W-1:0] subkey_15,
    output logic                subkeys_valid
);

    ks_state_t            state;
    ks_state_t            next_state;
    logic                 load_key;
    logic                 gen_step;

    logic [3:0]           round_cnt;
    logic [HALF_W-1:0]    c_reg;
    logic [HALF_W-1:0]    d_reg;
    logic                 decrypt_latched;
    logic                 valid_reg;
    logic [SUBKEY_W-1:0]  subkey_reg [NUM_ROUNDS];

    logic [CD_W-1:0]      cd_loaded;
    logic [HALF_W-1:0]    c_rot;
    logic [HALF_W-1:0]    d_rot;
    logic [SUBKEY_W-1:0]  round_subkey;
    logic [SUBKEY_W-1:0]  subkey_sel [NUM_ROUNDS];

    // DES parity bits 8, 16, ..., 64 never reach PC-1.
    logic key_parity_unused;
    assign key_parity_unused = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                                 key_in[24], key_in[16], key_in[8],  key_in[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A key is accepted in IDLE and in DONE alike, so a new key in DONE goes
    // straight into GEN without passing through IDLE.
    always_comb begin
        next_state = state;
        key_ready  = 1'b0;
        load_key   = 1'b0;
        gen_step   = 1'b0;
        case (state)
            IDLE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    load_key   = 1'b1;
                    next_state = GEN;
                end
            end
            GEN: begin
                gen_step = 1'b1;
                if (round_cnt == 4'd15) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    load_key   = 1'b1;
                    next_state = GEN;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        cd_loaded = pc1_permute(key_in);
        c_rot     = rotl_half(c_reg, SHIFT_TABLE[round_cnt]);
        d_rot     = rotl_half(d_reg, SHIFT_TABLE[round_cnt]);
    end

    pc2_permutation u_pc2 (
        .cd_in      ({c_rot, d_rot}),
        .subkey_out (round_subkey)
    );

    // The counter wraps back to 0 after round 16, which is also where the next
    // load would put it.
    always_ff @(posedge clk) begin
        if (rst) begin
            round_cnt       <= '0;
            c_reg           <= '0;
            d_reg           <= '0;
            decrypt_latched <= 1'b0;
            for (int i = 0; i < NUM_ROUNDS; i++) begin
                subkey_reg[i] <= '0;
            end
        end else if (load_key) begin
            round_cnt       <= '0;
            c_reg           <= cd_loaded[CD_W-1:HALF_W];
            d_reg           <= cd_loaded[HALF_W-1:0];
            decrypt_latched <= decrypt;
        end else if (gen_step) begin
            round_cnt             <= round_cnt + 4'd1;
            c_reg                 <= c_rot;
            d_reg                 <= d_rot;
            subkey_reg[round_cnt] <= round_subkey;
        end
    end

    // Valid is registered one cycle behind entry into DONE, so it rises 17
    // edges after the accepting edge. It drops on the very edge that accepts a
    // new key.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= (state == DONE) && !load_key;
        end
    end

    assign subkeys_valid = valid_reg;

    // Order is selected from the latched decrypt flag, so toggling the live
    // input while outputs are valid cannot disturb them.
    always_comb begin
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            subkey_sel[i] = decrypt_latched ? subkey_reg[4'(NUM_ROUNDS - 1 - i)]
                                            : subkey_reg[i];
        end
    end

    assign subkey_0  = subkey_sel[0];
    assign subkey_1  = subkey_sel[1];
    assign subkey_2  = subkey_sel[2];
    assign subkey_3  = subkey_sel[3];
    assign subkey_4  = subkey_sel[4];
    assign subkey_5  = subkey_sel[5];
    assign subkey_6  = subkey_sel[6];
    assign subkey_7  = subkey_sel[7];
    assign subkey_8  = subkey_sel[8];
    assign subkey_9  = subkey_sel[9];
    assign subkey_10 = subkey_sel[10];
    assign subkey_11 = subkey_sel[11];
    assign subkey_12 = subkey_sel[12];
    assign subkey_13 = subkey_sel[13];
    assign subkey_14 = subkey_sel[14];
    assign subkey_15 = subkey_sel[15];

endmodule

// File: tb/tb_key_schedule_gen.sv
// -----------------------------------------------------------------------------
// tb_key_schedule_gen
// Directed bench for key_schedule_gen. The expected 16 subkeys for each issued
// key are computed by a reference model and queued when the key is driven.
// They are popped and compared when subkeys_valid rises.
// -----------------------------------------------------------------------------
module tb_key_schedule_gen;

    logic        clk;
    logic        rst;
    logic [63:0] key_in;
    logic        key_valid;
    logic        decrypt;
    logic        key_ready;
    logic        subkeys_valid;
    logic [47:0] sk [16];

    int compared   = 0;
    int mismatched = 0;

    logic [15:0][47:0] exp_q [$];

    localparam int PC1_REF [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2_REF [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int SHIFT_REF [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    key_schedule_gen dut (
        .clk           (clk),
        .rst           (rst),
        .key_in        (key_in),
        .key_valid     (key_valid),
        .decrypt       (decrypt),
        .key_ready     (key_ready),
        .subkey_0      (sk[0]),
        .subkey_1      (sk[1]),
        .subkey_2      (sk[2]),
        .subkey_3      (sk[3]),
        .subkey_4      (sk[4]),
        .subkey_5      (sk[5]),
        .subkey_6      (sk[6]),
        .subkey_7      (sk[7]),
        .subkey_8      (sk[8]),
        .subkey_9      (sk[9]),
        .subkey_10     (sk[10]),
        .subkey_11     (sk[11]),
        .subkey_12     (sk[12]),
        .subkey_13     (sk[13]),
        .subkey_14     (sk[14]),
        .subkey_15     (sk[15]),
        .subkeys_valid (subkeys_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round subkey built straight from the key: C and D are rotated by the
    // cumulative shift up to this round, using 1-based DES bit numbering.
    function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int round);
        logic cd [1:56];
        logic cr [1:56];
        logic [47:0] k;
        int s;
        for (int j = 1; j <= 56; j++) cd[j] = key[64 - PC1_REF[j-1]];
        s = 0;
        for (int r = 0; r <= round; r++) s += SHIFT_REF[r];
        for (int j = 1; j <= 28; j++) begin
            cr[j]      = cd[((j - 1 + s) % 28) + 1];
            cr[28 + j] = cd[28 + ((j - 1 + s) % 28) + 1];
        end
        k = '0;
        for (int j = 1; j <= 48; j++) k[48 - j] = cr[PC2_REF[j-1]];
        return k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives one key for one accepting edge and queues its expected outputs.
    task automatic applyStimulus(input logic [63:0] key, input logic dec);
        logic [15:0][47:0] e;
        for (int i = 0; i < 16; i++) e[i] = ref_subkey(key, dec ? 15 - i : i);
        checkVal("key_ready_before_accept", {63'd0, key_ready}, 64'd1);
        exp_q.push_back(e);
        key_in    = key;
        decrypt   = dec;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    // Counts edges after the accepting edge until subkeys_valid rises.
    task automatic waitValid();
        int n;
        n = 0;
        while (subkeys_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checkVal("latency_edges", 64'(n), 64'd17);
    endtask

    task automatic checkOutput();
        logic [15:0][47:0] e;
        if (exp_q.size() == 0) begin
            checkVal("scoreboard_nonempty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            checkVal("subkeys_valid", {63'd0, subkeys_valid}, 64'd1);
            for (int i = 0; i < 16; i++) begin
                checkVal($sformatf("subkey_%0d", i), {16'd0, sk[i]}, {16'd0, e[i]});
            end
        end
    endtask

    initial begin
        logic [15:0][47:0] discard;
        logic [63:0] rkey;
        logic [63:0] other_key;
        logic        rdec;

        $display("[TB] start");
        rst       = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        decrypt   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkVal("reset_key_ready", {63'd0, key_ready}, 64'd1);
        checkVal("reset_valid", {63'd0, subkeys_valid}, 64'd0);
        checkVal("reset_subkey_0", {16'd0, sk[0]}, 64'd0);
        checkVal("reset_subkey_15", {16'd0, sk[15]}, 64'd0);

        // Reference key, encrypt order
        applyStimulus(64'h133457799BBCDFF1, 1'b0);
        waitValid();
        checkOutput();
        checkVal("enc_k1_const", {16'd0, sk[0]}, {16'd0, 48'h1B02EFFC7072});
        checkVal("enc_k16_const", {16'd0, sk[15]}, {16'd0, 48'hCB3D8B0E17F5});

        // Live decrypt toggle in DONE must not disturb outputs
        decrypt = 1'b1;
        tick();
        tick();
        checkVal("live_dec_subkey_0", {16'd0, sk[0]}, {16'd0, 48'h1B02EFFC7072});
        checkVal("live_dec_valid", {63'd0, subkeys_valid}, 64'd1);

        // Same key, decrypt order, accepted from DONE
        applyStimulus(64'h133457799BBCDFF1, 1'b1);
        checkVal("done_restart_valid_low", {63'd0, subkeys_valid}, 64'd0);
        checkVal("done_restart_not_ready", {63'd0, key_ready}, 64'd0);
        waitValid();
        checkOutput();
        checkVal("dec_k16_const", {16'd0, sk[0]}, {16'd0, 48'hCB3D8B0E17F5});
        checkVal("dec_k1_const", {16'd0, sk[15]}, {16'd0, 48'h1B02EFFC7072});

        // Parity-only and all-zero keys give all-zero subkeys
        applyStimulus(64'h0101010101010101, 1'b0);
        waitValid();
        checkOutput();
        checkVal("parity_key_subkey_7", {16'd0, sk[7]}, 64'd0);
        applyStimulus(64'h0, 1'b1);
        waitValid();
        checkOutput();

        // Reset in the middle of generation
        applyStimulus(64'h133457799BBCDFF1, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        discard = exp_q.pop_front();
        checkVal("abort_valid", {63'd0, subkeys_valid}, 64'd0);
        checkVal("abort_key_ready", {63'd0, key_ready}, 64'd1);
        for (int i = 0; i < 16; i++) begin
            checkVal($sformatf("abort_subkey_%0d", i), {16'd0, sk[i]}, 64'd0);
        end
        rst = 1'b0;
        tick();
        checkVal("post_reset_key_ready", {63'd0, key_ready}, 64'd1);
        applyStimulus(64'h133457799BBCDFF1, 1'b0);
        waitValid();
        checkOutput();

        // key_valid held with another key during GEN is ignored
        other_key = 64'hA5A5_5A5A_0F0F_F0F0;
        applyStimulus(64'h0E329232EA6D0D73, 1'b0);
        key_in    = other_key;
        decrypt   = 1'b1;
        key_valid = 1'b1;
        checkVal("gen_not_ready", {63'd0, key_ready}, 64'd0);
        for (int i = 0; i < 16; i++) tick();
        key_valid = 1'b0;
        tick();
        checkOutput();
        applyStimulus(other_key, 1'b1);
        checkVal("second_key_valid_low", {63'd0, subkeys_valid}, 64'd0);
        waitValid();
        checkOutput();

        // A few random keys with random order
        for (int n = 0; n < 3; n++) begin
            rkey = {$urandom(), $urandom()};
            rdec = 1'($urandom_range(0, 1));
            applyStimulus(rkey, rdec);
            waitValid();
            checkOutput();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
